// File: rtl/dm_scan_reader.sv
// rtl/dm_scan_reader.sv - walks a data-memory word range and holds each word for the LED display
// Optional: DM_SCAN_CHECKSUM_EN adds a running sum of captured words on checksum.

module dm_scan_reader #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int DWELL_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              step,
    input  logic              loop,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic [ADDR_W-1:0] DM_Addr,
    output logic              dm_rd_en,
    input  logic [DATA_W-1:0] M_R_Data,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    // One counter serves both the read-latency wait and the display dwell.
    localparam int CNT_W = ($clog2(DWELL_CYC) < 2) ? 2 : $clog2(DWELL_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] lo_q;
    logic [ADDR_W-1:0] hi_q;
    logic [CNT_W-1:0]  cnt;
    logic              start_ok;
    logic              adv;
    logic              capture;
    logic              at_hi;

    assign at_hi   = (ptr == hi_q);
    assign capture = (state == S_CAPTURE) && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        adv        = 1'b0;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        start_ok   = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
                S_ISSUE:   state_next = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: state_next = S_DWELL;
                S_DWELL: begin
                    if (step_mode ? step : (cnt == '0)) begin
                        adv        = 1'b1;
                        state_next = (at_hi && !loop) ? S_DONE : S_ISSUE;
                    end
                end
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            lo_q <= '0;
            hi_q <= '0;
            cnt  <= '0;
        end else begin
            if (start_ok) begin
                lo_q <= addr_lo;
                hi_q <= addr_hi;
                ptr  <= addr_lo;
            end else if (adv && !(at_hi && !loop)) begin
                ptr <= at_hi ? lo_q : ptr + 1'b1;
            end

            case (state)
                S_ISSUE:   cnt <= CNT_W'(RD_LAT - 1);
                S_WAIT:    cnt <= cnt - 1'b1;
                S_CAPTURE: cnt <= CNT_W'(DWELL_CYC - 1);
                S_DWELL: begin
                    if (!step_mode && cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default:   cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data  <= '0;
            cur_addr   <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= capture;
            if (capture) begin
                disp_data <= M_R_Data;
                cur_addr  <= ptr;
            end
        end
    end

    // ptr only moves on entry to ISSUE, so it already is the held read address.
    assign DM_Addr  = ptr;
    assign dm_rd_en = (state == S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_WAIT) ||
                      (state == S_CAPTURE) || (state == S_DWELL);
    assign done     = (state == S_DONE);

`ifdef DM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (capture) begin
            sum_q <= sum_q + M_R_Data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dm_scan_reader.sv
// tb/tb_dm_scan_reader.sv - self-checking bench for dm_scan_reader with a latency-modelled RAM

module tb_dm_scan_reader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int DWELL  = 4;
    localparam int PERIOD = RD_LAT + 1 + DWELL;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              step_mode = 1'b0;
    logic              step = 1'b0;
    logic              loop = 1'b0;
    logic [ADDR_W-1:0] addr_lo = '0;
    logic [ADDR_W-1:0] addr_hi = '0;
    logic [ADDR_W-1:0] DM_Addr;
    logic              dm_rd_en;
    logic [DATA_W-1:0] M_R_Data;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic [ADDR_W-1:0] cur_addr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dm_scan_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .DWELL_CYC(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .step_mode(step_mode), .step(step), .loop(loop),
        .addr_lo(addr_lo), .addr_hi(addr_hi),
        .DM_Addr(DM_Addr), .dm_rd_en(dm_rd_en), .M_R_Data(M_R_Data),
        .disp_data(disp_data), .disp_valid(disp_valid), .cur_addr(cur_addr),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] word_of(input int a);
        return DATA_W'(a) * 32'h11111111;
    endfunction

    // RAM: data valid RD_LAT cycles after the strobe, junk otherwise.
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic [RD_LAT-1:0] pipe_v = '0;
    logic [DATA_W-1:0] junk = 32'hdeadbeef;

    always @(posedge clk) begin
        junk      <= $urandom;
        pipe_v[0] <= dm_rd_en;
        pipe_d[0] <= word_of(int'(DM_Addr));
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
    end
    assign M_R_Data = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

    int              rd_addr_q[$];
    int              rd_cyc_q[$];
    logic [DATA_W-1:0] dv_data_q[$];
    int              dv_cyc_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_rd_en) begin
                rd_addr_q.push_back(int'(DM_Addr));
                rd_cyc_q.push_back(cyc);
            end
            if (disp_valid) begin
                dv_data_q.push_back(disp_data);
                dv_cyc_q.push_back(cyc);
            end
        end
    end

    // Reference: addresses visited from lo up to hi, modulo 64.
    int exp_addr_q[$];

    function automatic void model_range(input int lo, input int hi);
        int n;
        n = (((hi - lo) % 64) + 64) % 64 + 1;
        exp_addr_q.delete();
        for (int k = 0; k < n; k++) exp_addr_q.push_back((lo + k) % 64);
    endfunction

    function automatic logic [DATA_W-1:0] exp_ck(input int count);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int k = 0; k < count; k++) s = s + word_of(exp_addr_q[k % exp_addr_q.size()]);
`ifdef DM_SCAN_CHECKSUM_EN
        return s;
`else
        return (s & '0);
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        dv_data_q.delete();
        dv_cyc_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({DM_Addr, dm_rd_en, disp_data, disp_valid, cur_addr, busy, done, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_hold: addr=%0h rd=%b data=%0h dv=%b cur=%0h busy=%b done=%b ck=%0h expected all 0",
                     DM_Addr, dm_rd_en, disp_data, disp_valid, cur_addr, busy, done, checksum);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({dm_rd_en, busy, done, disp_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: rd=%b busy=%b done=%b dv=%b expected 0", dm_rd_en, busy, done, disp_valid);
        end
    endtask

    task automatic test_scan_ranges();
        int lo, hi, n, got, gs;
        logic [DATA_W-1:0] gd;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) begin
                lo = 2; hi = 4;
            end else if (t == 1) begin
                lo = 62; hi = 1;
            end else begin
                lo = $urandom_range(0, 63);
                hi = (lo + $urandom_range(0, 5)) % 64;
            end
            model_range(lo, hi);
            n = exp_addr_q.size();
            clear_mon();
            step_mode = 1'b0; loop = 1'b0;
            addr_lo = ADDR_W'(lo); addr_hi = ADDR_W'(hi);
            pulse_start();
            for (int c = 0; c < n * PERIOD + 20 && done !== 1'b1; c++) tick();
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL scan_done[%0d]: done=%b expected 1", t, done);
            end
            checks++;
            if (rd_addr_q.size() != n) begin
                errors++;
                $display("FAIL scan_reads[%0d]: got %0d reads expected %0d", t, rd_addr_q.size(), n);
            end
            for (int k = 0; k < n; k++) begin
                got = (k < rd_addr_q.size()) ? rd_addr_q[k] : -1;
                checks++;
                if (got != exp_addr_q[k]) begin
                    errors++;
                    $display("FAIL scan_addr[%0d.%0d]: got %0d expected %0d", t, k, got, exp_addr_q[k]);
                end
                gd = (k < dv_data_q.size()) ? dv_data_q[k] : 'x;
                checks++;
                if (gd !== word_of(exp_addr_q[k])) begin
                    errors++;
                    $display("FAIL scan_data[%0d.%0d]: got %0h expected %0h", t, k, gd, word_of(exp_addr_q[k]));
                end
                gs = (k < dv_cyc_q.size() && k < rd_cyc_q.size()) ? dv_cyc_q[k] - rd_cyc_q[k] : -1;
                checks++;
                if (gs != RD_LAT + 1) begin
                    errors++;
                    $display("FAIL scan_latency[%0d.%0d]: got %0d expected %0d", t, k, gs, RD_LAT + 1);
                end
                if (k > 0) begin
                    gs = (k < rd_cyc_q.size()) ? rd_cyc_q[k] - rd_cyc_q[k-1] : -1;
                    checks++;
                    if (gs != PERIOD) begin
                        errors++;
                        $display("FAIL scan_spacing[%0d.%0d]: got %0d expected %0d", t, k, gs, PERIOD);
                    end
                end
            end
            checks++;
            if (cur_addr !== ADDR_W'(hi) || disp_data !== word_of(hi) || busy !== 1'b0) begin
                errors++;
                $display("FAIL scan_final[%0d]: cur=%0d data=%0h busy=%b expected %0d %0h 0",
                         t, cur_addr, disp_data, busy, hi, word_of(hi));
            end
            checks++;
            if (checksum !== exp_ck(n)) begin
                errors++;
                $display("FAIL scan_checksum[%0d]: got %0h expected %0h", t, checksum, exp_ck(n));
            end
        end
    endtask

    task automatic test_loop();
        model_range(3, 4);
        clear_mon();
        step_mode = 1'b0; loop = 1'b1; addr_lo = 6'd3; addr_hi = 6'd4;
        pulse_start();
        for (int c = 0; c < 5 * PERIOD + 20 && rd_addr_q.size() < 5; c++) tick();
        pulse_stop();
        tick();
        checks++;
        if (rd_addr_q.size() != 5 || dv_data_q.size() != 4) begin
            errors++;
            $display("FAIL loop_counts: reads=%0d shows=%0d expected 5 4", rd_addr_q.size(), dv_data_q.size());
        end
        for (int k = 0; k < 5 && k < rd_addr_q.size(); k++) begin
            checks++;
            if (rd_addr_q[k] != exp_addr_q[k % 2]) begin
                errors++;
                $display("FAIL loop_addr[%0d]: got %0d expected %0d", k, rd_addr_q[k], exp_addr_q[k % 2]);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || disp_data !== word_of(4)) begin
            errors++;
            $display("FAIL loop_stop: busy=%b done=%b data=%0h expected 0 0 %0h", busy, done, disp_data, word_of(4));
        end
        repeat (5) tick();
        checks++;
        if (checksum !== exp_ck(4)) begin
            errors++;
            $display("FAIL loop_checksum: got %0h expected %0h", checksum, exp_ck(4));
        end
        loop = 1'b0;
    endtask

    task automatic test_stop_wait();
        clear_mon();
        step_mode = 1'b0; loop = 1'b0; addr_lo = 6'd0; addr_hi = 6'd10;
        pulse_start();
        for (int c = 0; c < 3 * PERIOD + 20 && rd_addr_q.size() < 3; c++) tick();
        pulse_stop();
        tick();
        checks++;
        if (busy !== 1'b0 || dm_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stop_ctrl: busy=%b rd=%b expected 0 0", busy, dm_rd_en);
        end
        checks++;
        if (disp_data !== word_of(1) || cur_addr !== 6'd1 || dv_data_q.size() != 2) begin
            errors++;
            $display("FAIL stop_hold: data=%0h cur=%0d shows=%0d expected %0h 1 2",
                     disp_data, cur_addr, dv_data_q.size(), word_of(1));
        end
        repeat (10) tick();
        checks++;
        if (rd_addr_q.size() != 3) begin
            errors++;
            $display("FAIL stop_quiet: reads=%0d expected 3", rd_addr_q.size());
        end
    endtask

    task automatic test_step_mode();
        model_range(5, 5);
        clear_mon();
        step_mode = 1'b1; loop = 1'b1; addr_lo = 6'd5; addr_hi = 6'd5;
        pulse_start();
        for (int c = 0; c < 20 && dv_data_q.size() < 1; c++) tick();
        repeat (20) tick();
        checks++;
        if (rd_addr_q.size() != 1 || dv_data_q.size() != 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL step_hold: reads=%0d shows=%0d busy=%b expected 1 1 1",
                     rd_addr_q.size(), dv_data_q.size(), busy);
        end
        pulse_step();
        for (int c = 0; c < 20 && dv_data_q.size() < 2; c++) tick();
        repeat (10) tick();
        checks++;
        if (rd_addr_q.size() != 2 || dv_data_q.size() != 2) begin
            errors++;
            $display("FAIL step_advance: reads=%0d shows=%0d expected 2 2", rd_addr_q.size(), dv_data_q.size());
        end else begin
            checks++;
            if (rd_addr_q[1] != 5 || dv_data_q[1] !== word_of(5)) begin
                errors++;
                $display("FAIL step_reread: addr=%0d data=%0h expected 5 %0h", rd_addr_q[1], dv_data_q[1], word_of(5));
            end
        end
        checks++;
        if (checksum !== exp_ck(2)) begin
            errors++;
            $display("FAIL step_checksum: got %0h expected %0h", checksum, exp_ck(2));
        end
        pulse_stop();
        pulse_step();
        repeat (5) tick();
        checks++;
        if (rd_addr_q.size() != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL step_idle_ignored: reads=%0d busy=%b expected 2 0", rd_addr_q.size(), busy);
        end
        step_mode = 1'b0; loop = 1'b0;
    endtask

    task automatic test_start_stop_same();
        clear_mon();
        addr_lo = 6'd1; addr_hi = 6'd2;
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (10) tick();
        checks++;
        if (rd_addr_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same: reads=%0d busy=%b done=%b expected 0 0 0",
                     rd_addr_q.size(), busy, done);
        end
    endtask

    task automatic test_async_reset();
        clear_mon();
        addr_lo = 6'd0; addr_hi = 6'd3;
        pulse_start();
        for (int c = 0; c < 20 && dv_data_q.size() < 1; c++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: busy=%b expected 1", busy);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({DM_Addr, dm_rd_en, disp_data, disp_valid, cur_addr, busy, done, checksum} !== '0) begin
            errors++;
            $display("FAIL areset_async: addr=%0h data=%0h cur=%0h busy=%b done=%b ck=%0h expected all 0",
                     DM_Addr, disp_data, cur_addr, busy, done, checksum);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_range(7, 7);
        clear_mon();
        addr_lo = 6'd7; addr_hi = 6'd7;
        pulse_start();
        for (int c = 0; c < PERIOD + 20 && done !== 1'b1; c++) tick();
        checks++;
        if (done !== 1'b1 || disp_data !== 32'h77777777 || cur_addr !== 6'd7) begin
            errors++;
            $display("FAIL areset_rescan: done=%b data=%0h cur=%0d expected 1 77777777 7", done, disp_data, cur_addr);
        end
        checks++;
        if (checksum !== exp_ck(1)) begin
            errors++;
            $display("FAIL areset_checksum: got %0h expected %0h", checksum, exp_ck(1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan_ranges();
        test_loop();
        test_stop_wait();
        test_step_mode();
        test_start_stop_same();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
